alu_share_arbiter: RTL and testbench

//  Shares one ALU instance between N_REQ requesters, e.g. the execute stage and the branch-compare unit.

---
 rtl/alu_share_arbiter_if.sv | 47 ++++
 rtl/alu_share_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, ALU and response signals around alu_share_arbiter.
// slave is the arbiter's view; master is the environment (requesters, ALU, response sink).
interface alu_share_arbiter_if #(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ-1:0]         req_alusrc;
  logic [3*N_REQ-1:0]       req_aluctrl;
  logic [D_WIDTH*N_REQ-1:0] req_op1;
  logic [D_WIDTH*N_REQ-1:0] req_imm;
  logic [D_WIDTH*N_REQ-1:0] req_reg;

  logic                     alu_alusrc;
  logic [2:0]               alu_aluctrl;
  logic [D_WIDTH-1:0]       alu_aluop1;
  logic [D_WIDTH-1:0]       alu_immop;
  logic [D_WIDTH-1:0]       alu_regop2;
  logic [D_WIDTH-1:0]       alu_aluout;
  logic                     alu_eq;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [D_WIDTH-1:0]       rsp_data;
  logic                     rsp_eq;

  modport slave (
    input  req_valid, req_alusrc, req_aluctrl, req_op1, req_imm, req_reg,
    output req_ready,
    output alu_alusrc, alu_aluctrl, alu_aluop1, alu_immop, alu_regop2,
    input  alu_aluout, alu_eq,
    output rsp_valid, rsp_id, rsp_data, rsp_eq,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_alusrc, req_aluctrl, req_op1, req_imm, req_reg,
    input  req_ready,
    input  alu_alusrc, alu_aluctrl, alu_aluop1, alu_immop, alu_regop2,
    output alu_aluout, alu_eq,
    input  rsp_valid, rsp_id, rsp_data, rsp_eq,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between N_REQ requesters with a one-entry,
// ID-tagged response buffer. Define ALU_ARB_STATS_EN to add saturating per-requester grant_cnt.
module alu_share_arbiter #(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned N_REQ   = 2,
`ifdef ALU_ARB_STATS_EN
  parameter int unsigned CNT_W   = 16,
`endif
  parameter int unsigned ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef ALU_ARB_STATS_EN
  output logic [CNT_W*N_REQ-1:0]   grant_cnt,
`endif
  alu_share_arbiter_if.slave       bus
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [D_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_eq_q, rsp_eq_d;

  logic [ID_W-1:0]    win;
  logic               any_valid;
  logic               can_issue;
  logic               grant;
  logic [N_REQ-1:0]   ready;

  // Lowest valid index overall is the wrap-around candidate; the lowest valid index at or above
  // ptr overrides it, which yields the first valid requester scanning ptr, ptr+1, ... mod N_REQ.
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        win       = ID_W'(i);
        any_valid = 1'b1;
      end
    end
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && (ID_W'(i) >= ptr_q)) begin
        win = ID_W'(i);
      end
    end
  end

  assign can_issue = (state_q == StEmpty) || bus.rsp_ready;
  assign grant     = !rst && can_issue && any_valid;

  always_comb begin
    ready           = '0;
    bus.alu_alusrc  = 1'b0;
    bus.alu_aluctrl = '0;
    bus.alu_aluop1  = '0;
    bus.alu_immop   = '0;
    bus.alu_regop2  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant && (win == ID_W'(i))) begin
        ready[i]        = 1'b1;
        bus.alu_alusrc  = bus.req_alusrc[i];
        bus.alu_aluctrl = bus.req_aluctrl[3*i +: 3];
        bus.alu_aluop1  = bus.req_op1[D_WIDTH*i +: D_WIDTH];
        bus.alu_immop   = bus.req_imm[D_WIDTH*i +: D_WIDTH];
        bus.alu_regop2  = bus.req_reg[D_WIDTH*i +: D_WIDTH];
      end
    end
  end

  assign bus.req_ready = ready;

  // A grant while FULL implies rsp_ready, so the pop and the refill share one edge.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_eq_d   = rsp_eq_q;
    if (grant) begin
      state_d    = StFull;
      rsp_id_d   = win;
      rsp_data_d = bus.alu_aluout;
      rsp_eq_d   = bus.alu_eq;
      ptr_d      = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
    end else if ((state_q == StFull) && bus.rsp_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_eq_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_eq_q   <= rsp_eq_d;
    end
  end

  assign bus.rsp_valid = (state_q == StFull);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_eq    = rsp_eq_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W*N_REQ-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (ready[i] && bus.req_valid[i] && (cnt_q[CNT_W*i +: CNT_W] != {CNT_W{1'b1}})) begin
        cnt_d[CNT_W*i +: CNT_W] = cnt_q[CNT_W*i +: CNT_W] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin reference model; stats checks when ALU_ARB_STATS_EN is set.
module tb_alu_share_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 2;
  localparam int unsigned IW = 1;
  localparam int unsigned AW = 4 + 3 * DW;
`ifdef ALU_ARB_STATS_EN
  localparam int unsigned CW = 4;
  logic [CW*NR-1:0] grant_cnt;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_share_arbiter_if #(.D_WIDTH(DW), .N_REQ(NR), .ID_W(IW)) bus ();

  alu_share_arbiter #(
    .D_WIDTH(DW),
    .N_REQ  (NR),
`ifdef ALU_ARB_STATS_EN
    .CNT_W  (CW),
`endif
    .ID_W   (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Requester state
  logic [NR-1:0] r_valid;
  logic          r_src  [NR];
  logic [2:0]    r_ctrl [NR];
  logic [DW-1:0] r_op1  [NR];
  logic [DW-1:0] r_imm  [NR];
  logic [DW-1:0] r_rg   [NR];

  // Reference model state
  bit            m_full;
  int            m_ptr;
  int            m_id;
  logic [DW-1:0] m_data;
  logic          m_eq;

  function automatic logic [DW-1:0] alu_out(input logic src, input logic [2:0] ctrl,
                                            input logic [DW-1:0] a, input logic [DW-1:0] imm,
                                            input logic [DW-1:0] rg);
    logic [DW-1:0] b;
    b = src ? imm : rg;
    case (ctrl)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return DW'(a < b);
      default: return '0;
    endcase
  endfunction

  function automatic logic alu_eq_fn(input logic src, input logic [DW-1:0] a,
                                     input logic [DW-1:0] imm, input logic [DW-1:0] rg);
    return a == (src ? imm : rg);
  endfunction

  // Combinational ALU stand-in
  always_comb begin
    bus.alu_aluout = alu_out(bus.alu_alusrc, bus.alu_aluctrl, bus.alu_aluop1, bus.alu_immop,
                             bus.alu_regop2);
    bus.alu_eq     = alu_eq_fn(bus.alu_alusrc, bus.alu_aluop1, bus.alu_immop, bus.alu_regop2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    bus.req_valid = r_valid;
    for (int i = 0; i < int'(NR); i++) begin
      bus.req_alusrc[i]          = r_src[i];
      bus.req_aluctrl[3*i +: 3]  = r_ctrl[i];
      bus.req_op1[DW*i +: DW]    = r_op1[i];
      bus.req_imm[DW*i +: DW]    = r_imm[i];
      bus.req_reg[DW*i +: DW]    = r_rg[i];
    end
  endtask

  task automatic new_fields(input int i);
    r_src[i]  = 1'($urandom_range(0, 1));
    r_ctrl[i] = 3'($urandom_range(0, 7));
    r_imm[i]  = $urandom();
    r_rg[i]   = $urandom();
    r_op1[i]  = ($urandom_range(0, 3) == 0) ? (r_src[i] ? r_imm[i] : r_rg[i]) : $urandom();
  endtask

  function automatic void model_reset();
    m_full = 1'b0;
    m_ptr  = 0;
    m_id   = 0;
    m_data = '0;
    m_eq   = 1'b0;
  endfunction

  // Winner for the current cycle, or -1 when nothing is granted.
  function automatic int model_pick(input logic rr);
    if (m_full && !rr) return -1;
    for (int k = 0; k < int'(NR); k++) begin
      int c;
      c = (m_ptr + k) % int'(NR);
      if (r_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_commit(input int w, input logic rr);
    if (w >= 0) begin
      m_full = 1'b1;
      m_id   = w;
      m_data = alu_out(r_src[w], r_ctrl[w], r_op1[w], r_imm[w], r_rg[w]);
      m_eq   = alu_eq_fn(r_src[w], r_op1[w], r_imm[w], r_rg[w]);
      m_ptr  = (w + 1) % int'(NR);
    end else if (m_full && rr) begin
      m_full = 1'b0;
    end
  endfunction

  function automatic logic [AW-1:0] model_alu(input int w);
    if (w < 0) return '0;
    return {r_src[w], r_ctrl[w], r_op1[w], r_imm[w], r_rg[w]};
  endfunction

  function automatic logic [NR-1:0] model_ready(input int w);
    if (w < 0) return '0;
    return NR'(1) << w;
  endfunction

  function automatic logic [AW-1:0] obs_alu();
    return {bus.alu_alusrc, bus.alu_aluctrl, bus.alu_aluop1, bus.alu_immop, bus.alu_regop2};
  endfunction

  task automatic test_reset();
    int w;
    r_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    drive();
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b expected 00", bus.req_ready);
    end
    checks++;
    if (obs_alu() !== '0) begin
      errors++; $display("FAIL reset_alu: got %h expected 0", obs_alu());
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_data} !== '0) begin
      errors++; $display("FAIL reset_rsp: got v=%b id=%0d eq=%b d=%h expected all 0",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_data);
    end
    tick();
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL reset_first_grant: got %b expected 01", bus.req_ready);
    end
    w = model_pick(1'b1);
    tick();
    model_commit(w, 1'b1);
    new_fields(w);
    drive();
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL reset_fill: rsp_valid got %b expected 1", bus.rsp_valid);
    end
    // Reset while FULL, with the pointer parked on requester 1.
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_midop: got v=%b ready=%b expected 0/00",
                         bus.rsp_valid, bus.req_ready);
    end
    tick();
    rst = 1'b0;
    model_reset();
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL reset_ptr_cleared: got %b expected 01", bus.req_ready);
    end
    w = model_pick(1'b1);
    tick();
    model_commit(w, 1'b1);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id} !== 2'b10) begin
      errors++; $display("FAIL reset_after_grant: got v=%b id=%0d expected 1/0",
                         bus.rsp_valid, bus.rsp_id);
    end
    r_valid = 2'b00;
    drive();
    w = model_pick(1'b1);
    tick();
    model_commit(w, 1'b1);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty: rsp_valid got %b expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_req0();
    int w;
    r_valid = 2'b01;
    r_src[0] = 1'b0; r_ctrl[0] = 3'b000; r_op1[0] = 32'd5; r_rg[0] = 32'd3;
    r_imm[0] = $urandom();
    bus.rsp_ready = 1'b1;
    drive();
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL req0_ready: got %b expected 01", bus.req_ready);
    end
    checks++;
    if (obs_alu() !== model_alu(0)) begin
      errors++; $display("FAIL req0_alu: got %h expected %h", obs_alu(), model_alu(0));
    end
    w = model_pick(1'b1);
    tick();
    model_commit(w, 1'b1);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_data} !== {1'b1, 1'b0, 1'b0, 32'd8}) begin
      errors++; $display("FAIL req0_rsp: got v=%b id=%0d eq=%b d=%0d expected 1/0/0/8",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_data);
    end
  endtask

  task automatic test_req1();
    int w;
    r_valid = 2'b10;
    r_src[1] = 1'b1; r_ctrl[1] = 3'b001; r_op1[1] = 32'd7; r_imm[1] = 32'd7; r_rg[1] = 32'd9;
    drive();
    #1;
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++; $display("FAIL req1_ready: got %b expected 10", bus.req_ready);
    end
    w = model_pick(1'b1);
    tick();
    model_commit(w, 1'b1);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_data} !== {1'b1, 1'b1, 1'b1, 32'd0}) begin
      errors++; $display("FAIL req1_rsp: got v=%b id=%0d eq=%b d=%0d expected 1/1/1/0",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_data);
    end
  endtask

  task automatic test_alternate();
    int w;
    r_valid = 2'b11;
    new_fields(0);
    new_fields(1);
    for (int k = 0; k < 6; k++) begin
      drive();
      #1;
      checks++;
      if (bus.req_ready !== model_ready(k % 2)) begin
        errors++; $display("FAIL alt_ready[%0d]: got %b expected %b", k, bus.req_ready,
                           model_ready(k % 2));
      end
      checks++;
      if (obs_alu() !== model_alu(k % 2)) begin
        errors++; $display("FAIL alt_alu[%0d]: got %h expected %h", k, obs_alu(),
                           model_alu(k % 2));
      end
      w = model_pick(1'b1);
      tick();
      model_commit(w, 1'b1);
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, IW'(k % 2), m_data}) begin
        errors++; $display("FAIL alt_rsp[%0d]: got v=%b id=%0d d=%h expected 1/%0d/%h", k,
                           bus.rsp_valid, bus.rsp_id, bus.rsp_data, k % 2, m_data);
      end
      new_fields(k % 2);
    end
  endtask

  task automatic test_backpressure();
    int w;
    bus.rsp_ready = 1'b0;
    drive();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({bus.req_ready, obs_alu()} !== '0) begin
        errors++; $display("FAIL bp_stall[%0d]: got ready=%b alu=%h expected 0", k,
                           bus.req_ready, obs_alu());
      end
      w = model_pick(1'b0);
      tick();
      model_commit(w, 1'b0);
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_data} !==
          {1'b1, IW'(m_id), m_eq, m_data}) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d eq=%b d=%h expected 1/%0d/%b/%h",
                           k, bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_data,
                           m_id, m_eq, m_data);
      end
    end
    bus.rsp_ready = 1'b1;
    #1;
    w = model_pick(1'b1);
    checks++;
    if (bus.req_ready !== model_ready(w) || w < 0) begin
      errors++; $display("FAIL bp_release_ready: got %b expected %b", bus.req_ready,
                         model_ready(w));
    end
    tick();
    model_commit(w, 1'b1);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, IW'(m_id), m_data}) begin
      errors++; $display("FAIL bp_release_rsp: got v=%b id=%0d d=%h expected 1/%0d/%h",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_data, m_id, m_data);
    end
  endtask

  task automatic test_random();
    int   w;
    logic rr;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < int'(NR); i++) begin
        if (!r_valid[i]) begin
          r_valid[i] = 1'($urandom_range(0, 1));
          new_fields(i);
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      bus.rsp_ready = rr;
      drive();
      #1;
      w = model_pick(rr);
      checks++;
      if (bus.req_ready !== model_ready(w)) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, bus.req_ready,
                           model_ready(w));
      end
      checks++;
      if (obs_alu() !== model_alu(w)) begin
        errors++; $display("FAIL rand_alu[%0d]: got %h expected %h", n, obs_alu(), model_alu(w));
      end
      tick();
      model_commit(w, rr);
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_data} !==
          {m_full, IW'(m_id), m_eq, m_data}) begin
        errors++; $display("FAIL rand_rsp[%0d]: got v=%b id=%0d eq=%b d=%h expected %b/%0d/%b/%h",
                           n, bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_data,
                           m_full, m_id, m_eq, m_data);
      end
      if (w >= 0) r_valid[w] = 1'b0;
    end
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    int w;
    rst = 1'b1;
    #1;
    r_valid = 2'b01;
    new_fields(0);
    bus.rsp_ready = 1'b1;
    drive();
    tick();
    rst = 1'b0;
    model_reset();
    checks++;
    if (grant_cnt !== '0) begin
      errors++; $display("FAIL stats_reset: got %h expected 0", grant_cnt);
    end
    for (int k = 0; k < 20; k++) begin
      #1;
      w = model_pick(1'b1);
      tick();
      model_commit(w, 1'b1);
      new_fields(0);
      drive();
      if (k == 9) begin
        checks++;
        if (grant_cnt !== 8'h0A) begin
          errors++; $display("FAIL stats_count10: got %h expected 0a", grant_cnt);
        end
      end
    end
    checks++;
    if (grant_cnt[3:0] !== 4'd15 || grant_cnt[7:4] !== 4'd0) begin
      errors++; $display("FAIL stats_saturate: got %h expected 0f", grant_cnt);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    r_valid = '0;
    for (int i = 0; i < int'(NR); i++) new_fields(i);
    drive();
    model_reset();
    test_reset();
    test_req0();
    test_req1();
    test_alternate();
    test_backpressure();
    test_random();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
